// File: rtl/wb_arbiter_2to1.sv
// Two-controller Wishbone classic arbiter: instruction fetch (I) and load/store (D)
// share one peripheral port. Ownership is registered and held for a whole cyc.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort a beat that never gets
// a response after TIMEOUT_CYCLES cycles of stb.
module wb_arbiter_2to1 #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ROUND_ROBIN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    // controller I
    input  logic                    i_i_cyc,
    input  logic                    i_i_stb,
    input  logic                    i_i_we,
    input  logic [ADDR_WIDTH-1:0]   i_i_adr,
    input  logic [DATA_WIDTH-1:0]   i_i_dat,
    input  logic [DATA_WIDTH/8-1:0] i_i_sel,
    output logic                    o_i_ack,
    output logic                    o_i_err,
    output logic [DATA_WIDTH-1:0]   o_i_dat,
    // controller D
    input  logic                    i_d_cyc,
    input  logic                    i_d_stb,
    input  logic                    i_d_we,
    input  logic [ADDR_WIDTH-1:0]   i_d_adr,
    input  logic [DATA_WIDTH-1:0]   i_d_dat,
    input  logic [DATA_WIDTH/8-1:0] i_d_sel,
    output logic                    o_d_ack,
    output logic                    o_d_err,
    output logic [DATA_WIDTH-1:0]   o_d_dat,
    // peripheral
    output logic                    o_p_cyc,
    output logic                    o_p_stb,
    output logic                    o_p_we,
    output logic [ADDR_WIDTH-1:0]   o_p_adr,
    output logic [DATA_WIDTH-1:0]   o_p_dat,
    output logic [DATA_WIDTH/8-1:0] o_p_sel,
    input  logic                    i_p_ack,
    input  logic                    i_p_err,
    input  logic [DATA_WIDTH-1:0]   i_p_dat,
    output logic [1:0]              o_owner
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

    // Reject configurations the datapath cannot represent.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_arbiter_2to1: TIMEOUT_CYCLES must be 1..65535");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("wb_arbiter_2to1: DATA_WIDTH must be a multiple of 8");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_I = 2'd1,
        ST_OWN_D = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_d_q, last_d_d;   // 1 = D was the last owner, 0 = I

    logic own_i, own_d;
    logic pass_cyc, pass_stb;
    logic kill;
    logic to_hit;

    // State and last-owner registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // Arbitration and release.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            ST_IDLE: begin
                if (i_i_cyc && i_d_cyc) begin
                    if (ROUND_ROBIN != 0 && last_d_q) state_d = ST_OWN_I;
                    else                              state_d = ST_OWN_D;
                end else if (i_i_cyc) begin
                    state_d = ST_OWN_I;
                end else if (i_d_cyc) begin
                    state_d = ST_OWN_D;
                end
            end
            ST_OWN_I: begin
                if (!i_i_cyc) begin
                    last_d_d = 1'b0;
                    state_d  = i_d_cyc ? ST_OWN_D : ST_IDLE;
                end
            end
            ST_OWN_D: begin
                if (!i_d_cyc) begin
                    last_d_d = 1'b1;
                    state_d  = i_i_cyc ? ST_OWN_I : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign own_i    = (state_q == ST_OWN_I);
    assign own_d    = (state_q == ST_OWN_D);
    assign pass_cyc = (own_i & i_i_cyc) | (own_d & i_d_cyc);
    assign pass_stb = (own_i & i_i_cyc & i_i_stb) | (own_d & i_d_cyc & i_d_stb);

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] to_cnt_q;
    logic        to_flag_q;   // beat aborted; keep bus off until owner drops cyc

    assign to_hit = pass_stb & ~to_flag_q & ~i_rst & (to_cnt_q == TO_LIMIT);
    assign kill   = i_rst | to_hit | to_flag_q;

    // Watchdog: count stalled stb cycles, latch the abort until release.
    always_ff @(posedge i_clk) begin
        if (i_rst || !o_p_stb || i_p_ack || i_p_err) to_cnt_q <= 16'd0;
        else                                         to_cnt_q <= to_cnt_q + 16'd1;

        if (i_rst || !pass_cyc) to_flag_q <= 1'b0;
        else if (to_hit)        to_flag_q <= 1'b1;
    end
`else
    assign to_hit = 1'b0;
    assign kill   = i_rst;
`endif

    // Peripheral request mux and response routing to the owner only.
    always_comb begin
        o_p_cyc = pass_cyc & ~kill;
        o_p_stb = pass_stb & ~kill;
        o_p_we  = 1'b0;
        o_p_adr = '0;
        o_p_dat = '0;
        o_p_sel = '0;
        o_i_ack = 1'b0;
        o_i_err = 1'b0;
        o_i_dat = '0;
        o_d_ack = 1'b0;
        o_d_err = 1'b0;
        o_d_dat = '0;
        o_owner = {own_d, own_i};
        if (own_i) begin
            o_p_we  = i_i_we;
            o_p_adr = i_i_adr;
            o_p_dat = i_i_dat;
            o_p_sel = SEL_WIDTH'(i_i_sel);
            o_i_ack = o_p_stb & i_p_ack;
            o_i_err = (o_p_stb & i_p_err) | to_hit;
            o_i_dat = i_p_dat;
        end else if (own_d) begin
            o_p_we  = i_d_we;
            o_p_adr = i_d_adr;
            o_p_dat = i_d_dat;
            o_p_sel = SEL_WIDTH'(i_d_sel);
            o_d_ack = o_p_stb & i_p_ack;
            o_d_err = (o_p_stb & i_p_err) | to_hit;
            o_d_dat = i_p_dat;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench for wb_arbiter_2to1: one round-robin instance and one
// fixed-priority instance driven by identical stimulus.
// Define WB_ARB_TIMEOUT_EN to also exercise the watchdog (limit 8).
module tb_wb_arbiter_2to1;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cyc, i_stb, i_we;
    logic [AW-1:0] i_adr;
    logic [DW-1:0] i_dat;
    logic [SW-1:0] i_sel;
    logic          d_cyc, d_stb, d_we;
    logic [AW-1:0] d_adr;
    logic [DW-1:0] d_dat;
    logic [SW-1:0] d_sel;
    logic          p_ack, p_err;
    logic [DW-1:0] p_rdat;

    logic          i_ack, i_err, d_ack, d_err;
    logic [DW-1:0] i_rdat, d_rdat;
    logic          p_cyc, p_stb, p_we;
    logic [AW-1:0] p_adr;
    logic [DW-1:0] p_wdat;
    logic [SW-1:0] p_sel;
    logic [1:0]    owner;

    logic          f_i_ack, f_i_err, f_d_ack, f_d_err;
    logic [DW-1:0] f_i_rdat, f_d_rdat;
    logic          f_p_cyc, f_p_stb, f_p_we;
    logic [AW-1:0] f_p_adr;
    logic [DW-1:0] f_p_wdat;
    logic [SW-1:0] f_p_sel;
    logic [1:0]    f_owner;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_i_cyc(i_cyc), .i_i_stb(i_stb), .i_i_we(i_we), .i_i_adr(i_adr), .i_i_dat(i_dat), .i_i_sel(i_sel),
        .o_i_ack(i_ack), .o_i_err(i_err), .o_i_dat(i_rdat),
        .i_d_cyc(d_cyc), .i_d_stb(d_stb), .i_d_we(d_we), .i_d_adr(d_adr), .i_d_dat(d_dat), .i_d_sel(d_sel),
        .o_d_ack(d_ack), .o_d_err(d_err), .o_d_dat(d_rdat),
        .o_p_cyc(p_cyc), .o_p_stb(p_stb), .o_p_we(p_we), .o_p_adr(p_adr), .o_p_dat(p_wdat), .o_p_sel(p_sel),
        .i_p_ack(p_ack), .i_p_err(p_err), .i_p_dat(p_rdat),
        .o_owner(owner)
    );

    wb_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)) dut_fp (
        .i_clk(clk), .i_rst(rst),
        .i_i_cyc(i_cyc), .i_i_stb(i_stb), .i_i_we(i_we), .i_i_adr(i_adr), .i_i_dat(i_dat), .i_i_sel(i_sel),
        .o_i_ack(f_i_ack), .o_i_err(f_i_err), .o_i_dat(f_i_rdat),
        .i_d_cyc(d_cyc), .i_d_stb(d_stb), .i_d_we(d_we), .i_d_adr(d_adr), .i_d_dat(d_dat), .i_d_sel(d_sel),
        .o_d_ack(f_d_ack), .o_d_err(f_d_err), .o_d_dat(f_d_rdat),
        .o_p_cyc(f_p_cyc), .o_p_stb(f_p_stb), .o_p_we(f_p_we), .o_p_adr(f_p_adr), .o_p_dat(f_p_wdat), .o_p_sel(f_p_sel),
        .i_p_ack(p_ack), .i_p_err(p_err), .i_p_dat(p_rdat),
        .o_owner(f_owner)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_dat = '0; i_sel = '0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_dat = '0; d_sel = '0;
        p_ack = 0; p_err = 0; p_rdat = '0;
        tick;
        tick;

        // Reset state; a stray ack in IDLE must not be forwarded.
        rst = 1'b0;
        p_ack = 1'b1;
        #1;
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_pcyc", 32'(p_cyc), 32'h0);
        chk("rst_pstb", 32'(p_stb), 32'h0);
        chk("idle_iack", 32'(i_ack), 32'h0);
        chk("idle_dack", 32'(d_ack), 32'h0);
        p_ack = 1'b0;

        // I single read.
        i_cyc = 1; i_stb = 1; i_adr = 32'h1000_0000;
        #1;
        chk("t1_idle_pcyc", 32'(p_cyc), 32'h0);
        tick;
        chk("t1_owner", 32'(owner), 32'h1);
        chk("t1_pstb", 32'(p_stb), 32'h1);
        chk("t1_padr", p_adr, 32'h1000_0000);
        tick;
        p_ack = 1; p_rdat = 32'hDEAD_BEEF;
        #1;
        chk("t1_iack", 32'(i_ack), 32'h1);
        chk("t1_idat", i_rdat, 32'hDEAD_BEEF);
        chk("t1_dack", 32'(d_ack), 32'h0);
        chk("t1_ddat", d_rdat, 32'h0);
        tick;
        p_ack = 0; i_cyc = 0; i_stb = 0;
        #1;
        chk("t1_rel_pcyc", 32'(p_cyc), 32'h0);
        tick;
        chk("t1_idle", 32'(owner), 32'h0);

        // Tie from IDLE: D first (last owner I), one-cycle gap, then I.
        i_cyc = 1; i_stb = 1; i_adr = 32'h100;
        d_cyc = 1; d_stb = 1; d_adr = 32'h200;
        tick;
        chk("t2_owner", 32'(owner), 32'h2);
        chk("t2_padr", p_adr, 32'h200);
        chk("t2_f_owner", 32'(f_owner), 32'h2);
        p_ack = 1;
        #1;
        chk("t2_dack", 32'(d_ack), 32'h1);
        chk("t2_iack", 32'(i_ack), 32'h0);
        tick;
        p_ack = 0; d_cyc = 0; d_stb = 0;
        #1;
        chk("t2_gap_pcyc", 32'(p_cyc), 32'h0);
        tick;
        chk("t2_owner_i", 32'(owner), 32'h1);
        chk("t2_pcyc_i", 32'(p_cyc), 32'h1);
        chk("t2_padr_i", p_adr, 32'h100);
        i_cyc = 0; i_stb = 0;
        tick;
        chk("t2_idle", 32'(owner), 32'h0);

        // Three ties: fixed priority always D, round robin alternates D, I, D.
        for (int k = 0; k < 3; k++) begin
            i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
            tick;
            chk("t3_f_owner", 32'(f_owner), 32'h2);
            chk("t3_rr_owner", 32'(owner), (k == 1) ? 32'h1 : 32'h2);
            i_cyc = 0; i_stb = 0; d_cyc = 0; d_stb = 0;
            tick;
            chk("t3_f_idle", 32'(f_owner), 32'h0);
        end

        // D bursts 4 writes while I waits.
        d_cyc = 1; d_stb = 1; d_we = 1; d_sel = 4'hF; d_adr = 32'h300; d_dat = '0;
        tick;
        i_cyc = 1; i_stb = 1; i_adr = 32'h400; i_we = 0;
        for (int b = 1; b <= 4; b++) begin
            d_dat = 32'(b);
            p_ack = 1;
            #1;
            chk("t4_pdat", p_wdat, 32'(b));
            chk("t4_pwe", 32'(p_we), 32'h1);
            chk("t4_psel", 32'(p_sel), 32'hF);
            chk("t4_owner", 32'(owner), 32'h2);
            chk("t4_dack", 32'(d_ack), 32'h1);
            chk("t4_iack", 32'(i_ack), 32'h0);
            tick;
        end
        p_ack = 0; d_cyc = 0; d_stb = 0; d_we = 0;
        #1;
        chk("t4_gap_pcyc", 32'(p_cyc), 32'h0);
        tick;
        chk("t4_owner_i", 32'(owner), 32'h1);
        chk("t4_padr_i", p_adr, 32'h400);
        chk("t4_pwe_i", 32'(p_we), 32'h0);
        chk("t4_f_owner_i", 32'(f_owner), 32'h1);
        p_err = 1;
        #1;
        chk("t4_ierr", 32'(i_err), 32'h1);
        chk("t4_derr", 32'(d_err), 32'h0);
        tick;
        p_err = 0; i_stb = 0; p_ack = 1;
        #1;
        chk("t4_nostb_iack", 32'(i_ack), 32'h0);
        chk("t4_nostb_pcyc", 32'(p_cyc), 32'h1);
        tick;
        p_ack = 0; i_stb = 1;

        // Reset while I owns with stb high (last owner is D before reset).
        rst = 1; p_ack = 1;
        #1;
        chk("t5_rst_iack", 32'(i_ack), 32'h0);
        chk("t5_rst_pcyc", 32'(p_cyc), 32'h0);
        tick;
        rst = 0; p_ack = 0; i_cyc = 0; i_stb = 0;
        #1;
        chk("t5_owner", 32'(owner), 32'h0);
        chk("t5_pcyc", 32'(p_cyc), 32'h0);
        i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
        tick;
        chk("t5_rr_owner", 32'(owner), 32'h2);
        chk("t5_f_owner", 32'(f_owner), 32'h2);
        i_cyc = 0; i_stb = 0; d_cyc = 0; d_stb = 0;
        tick;

`ifdef WB_ARB_TIMEOUT_EN
        // D read that is never acknowledged.
        d_cyc = 1; d_stb = 1; d_adr = 32'h500;
        tick;
        chk("t6_pstb", 32'(p_stb), 32'h1);
        chk("t6_derr0", 32'(d_err), 32'h0);
        for (int n = 1; n < 8; n++) begin
            tick;
            chk("t6_derr_wait", 32'(d_err), 32'h0);
        end
        tick;
        chk("t6_derr", 32'(d_err), 32'h1);
        chk("t6_pcyc", 32'(p_cyc), 32'h0);
        chk("t6_pstb_kill", 32'(p_stb), 32'h0);
        tick;
        chk("t6_derr_once", 32'(d_err), 32'h0);
        chk("t6_pcyc_held", 32'(p_cyc), 32'h0);
        chk("t6_owner", 32'(owner), 32'h2);
        d_cyc = 0; d_stb = 0;
        tick;
        chk("t6_idle", 32'(owner), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2to1.md
Name: wb_arbiter_2to1

Overview:
- Shares one Wishbone classic (non-pipelined) peripheral port between two controllers: instruction fetch (controller I) and load/store (controller D).
- Lets a single-ported memory or interconnect serve both CPU buses.
- Sits between the CPU's instruction/data bus outputs and the system bus.
- Ownership is registered and held for a whole Wishbone cycle (cyc high). Arbitration is fixed-priority or round-robin.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; select width is DATA_WIDTH/8.
- ROUND_ROBIN, 1, 1 = alternate on contention; 0 = D always wins contention.
- TIMEOUT_CYCLES, 255, watchdog limit (used only with the optional feature); range 1..65535.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_i_cyc, i_i_stb, i_i_we  in  1  controller I request
- i_i_adr  in  ADDR_WIDTH  controller I address
- i_i_dat  in  DATA_WIDTH  controller I write data
- i_i_sel  in  DATA_WIDTH/8  controller I byte select
- o_i_ack, o_i_err  out  1  controller I response
- o_i_dat  out  DATA_WIDTH  controller I read data
- i_d_* / o_d_*  same set as above for controller D
- o_p_cyc, o_p_stb, o_p_we  out  1  peripheral request
- o_p_adr  out  ADDR_WIDTH  peripheral address
- o_p_dat  out  DATA_WIDTH  peripheral write data
- o_p_sel  out  DATA_WIDTH/8  peripheral byte select
- i_p_ack, i_p_err  in  1  peripheral response
- i_p_dat  in  DATA_WIDTH  peripheral read data
- o_owner  out  2  01 = I owns, 10 = D owns, 00 = idle

Behaviour:
- Reset: state IDLE, last_owner = I (so D wins the first tie in RR mode). All o_p_*, o_*_ack, o_*_err = 0; o_owner = 00.
- States: IDLE, OWN_I, OWN_D.
- IDLE:
  - If only one cyc is high, grant it next cycle.
  - If both are high: with ROUND_ROBIN=1, grant the one that is not last_owner; with ROUND_ROBIN=0, grant D.
  - No peripheral signals are driven while in IDLE (o_p_cyc = o_p_stb = 0).
- OWN_x:
  - o_p_cyc = i_x_cyc and o_p_stb = i_x_stb, combinational passthrough.
  - we/adr/dat/sel are muxed from x.
  - o_x_ack/o_x_err/o_x_dat are passed from the peripheral.
  - The non-owner sees ack = err = 0 and dat = 0.
- Release: in OWN_x, when i_x_cyc = 0 (o_p_cyc drops the same cycle):
  - If the other controller's cyc is high, go directly to OWN_other and update last_owner = x.
  - Otherwise go to IDLE (last_owner = x).
  - Re-arbitration therefore inserts exactly one cycle with o_p_cyc = 0 between owners.
- Grant latency: a request arriving in IDLE sees o_p_stb one cycle later; minimum single-beat access is 2 cycles plus peripheral latency.
- Ack/err arriving while idle or with no stb are dropped, never forwarded.
- Owner holds the bus across multiple beats as long as its cyc stays high; there is no forced preemption.
- Reset mid-cycle: state returns to IDLE next edge. Outstanding acks in that cycle are not forwarded (outputs are gated by reset).

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears whenever o_p_stb = 0 or i_p_ack | i_p_err = 1, and increments while the owner's stb is high without a response.
  - On reaching TIMEOUT_CYCLES: assert o_x_err to the owner for exactly one cycle, force o_p_cyc = o_p_stb = 0 in that cycle and every cycle until the owner drops cyc, then release normally.
- When undefined: no counter, and the arbiter waits forever for ack/err.

Test Plan:
- Reset, then I single read at adr 0x10000000, peripheral acks 1 cycle after stb with 0xDEADBEEF -> o_owner = 01 one cycle after cyc; o_i_ack = 1 with o_i_dat = 0xDEADBEEF; o_d_ack stays 0; back to IDLE after cyc drops.
- I and D raise cyc in the same cycle from IDLE, ROUND_ROBIN=1 -> D is granted first. After D drops cyc, o_p_cyc is low for exactly 1 cycle, then I is granted with o_p_adr = I's address.
- Same stimulus with ROUND_ROBIN=0, repeated 3 times -> D wins all 3 ties.
- D holds cyc for 4 write beats (sel = 0xF, data 0x1..0x4) while I requests throughout -> I is stalled; the peripheral sees 4 D writes in order; I is granted on the cycle after D's cyc drops.
- Assert i_rst while OWN_I and stb are high -> next cycle o_owner = 00 and o_p_cyc = 0; the following D request is granted (last_owner = I).
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, peripheral never acks D -> o_d_err pulses once, 8 cycles after stb; o_p_cyc is 0 from that cycle on; IDLE after D drops cyc.
